// File: rtl/rs_alu_pkg.sv
// Shared types and constants for the ALU reservation station.
// Defines the decoded-instruction packet carried from issue to execute.
package rs_alu_pkg;

    localparam int XLEN        = 32;
    localparam int ROB_TAG_LEN = 5;
    localparam int RS_SIZE_DEF = 8;
    localparam int AGE_W_DEF   = 4;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7
    } alu_func_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_value;
        logic [XLEN-1:0] rs2_value;
        alu_func_t       alu_func;
        logic [4:0]      dest_reg_idx;
        logic            cond_branch;
        logic            uncond_branch;
    } id_ex_packet_t;

    // Tag 0 means "value already present" and must never match a broadcast.
    function automatic logic tag_hit(input logic                   cdb_valid,
                                     input logic [ROB_TAG_LEN-1:0] cdb_tag,
                                     input logic [ROB_TAG_LEN-1:0] tag);
        return cdb_valid && (tag != {ROB_TAG_LEN{1'b0}}) && (tag == cdb_tag);
    endfunction

endpackage

// File: rtl/rs_oldest_select.sv
// Picks the oldest ready entry using wrap-aware age comparison.
// Equal ages resolve to the lowest index; outputs a one-hot grant and its index.
module rs_oldest_select #(
    parameter int N     = 8,
    parameter int AGE_W = 4
) (
    input  logic [N-1:0]            i_ready,
    input  logic [N-1:0][AGE_W-1:0] i_age,
    output logic [N-1:0]            o_grant,
    output logic [$clog2(N)-1:0]    o_idx,
    output logic                    o_valid
);

    logic             w_win;
    logic [AGE_W-1:0] w_diff;

    // Entry i wins when no other ready entry is older, or equally old at a lower index.
    always_comb begin
        o_grant = '0;
        w_win   = 1'b0;
        w_diff  = '0;
        for (int i = 0; i < N; i++) begin
            w_win = i_ready[i];
            for (int j = 0; j < N; j++) begin
                w_diff = i_age[j] - i_age[i];
                if ((j != i) && i_ready[j]) begin
                    if (w_diff[AGE_W-1]) begin
                        w_win = 1'b0;
                    end else if ((w_diff == '0) && (j < i)) begin
                        w_win = 1'b0;
                    end else begin
                        w_win = w_win;
                    end
                end else begin
                    w_win = w_win;
                end
            end
            o_grant[i] = w_win;
        end
    end

    // Encode the grant; lowest set bit keeps the index well defined.
    always_comb begin
        o_idx   = '0;
        o_valid = |o_grant;
        for (int i = N - 1; i >= 0; i--) begin
            if (o_grant[i]) begin
                o_idx = ($clog2(N))'(i);
            end else begin
                o_idx = o_idx;
            end
        end
    end

endmodule

// File: rtl/rs_alu.sv
// Reservation station for ALU/branch ops: allocates, wakes operands from the CDB,
// and issues the oldest fully-ready entry to the ALU each cycle.
module rs_alu
    import rs_alu_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF,
    parameter int AGE_W   = AGE_W_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       alloc_en,
    input  id_ex_packet_t              id_packet_in,
    input  logic [ROB_TAG_LEN-1:0]     rs1_rob_tag,
    input  logic [ROB_TAG_LEN-1:0]     rs2_rob_tag,
    input  logic [ROB_TAG_LEN-1:0]     dest_rob_tag,
    input  logic                       cdb_valid,
    input  logic [ROB_TAG_LEN-1:0]     cdb_tag,
    input  logic [XLEN-1:0]            cdb_value,
    input  logic                       squash,
    input  logic                       fu_ready,
    output logic                       issue_valid,
    output id_ex_packet_t              issue_packet,
    output logic [ROB_TAG_LEN-1:0]     issue_rob_tag,
    output logic                       full,
    output logic [$clog2(RS_SIZE):0]   free_count
);

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic                   valid;
        id_ex_packet_t          packet;
        logic [ROB_TAG_LEN-1:0] rs1_tag;
        logic [ROB_TAG_LEN-1:0] rs2_tag;
        logic [ROB_TAG_LEN-1:0] dest_tag;
        logic [AGE_W-1:0]       age;
    } rs_entry_t;

    rs_entry_t                    r_entries [RS_SIZE];
    logic [AGE_W-1:0]             r_age_cnt;

    logic [RS_SIZE-1:0]           w_ready;
    logic [RS_SIZE-1:0][AGE_W-1:0] w_ages;
    logic [RS_SIZE-1:0]           w_grant;
    logic [IDX_W-1:0]             w_sel_idx;
    logic                         w_sel_valid;
    logic [IDX_W-1:0]             w_free_idx;
    logic [CNT_W-1:0]             w_free_cnt;
    logic                         w_full;
    logic                         w_alloc_fire;
    logic                         w_issue_fire;
    logic                         w_rs1_byp;
    logic                         w_rs2_byp;
    id_ex_packet_t                w_alloc_pkt;

    // Ready vector and ages feed the age-ordered selector.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_ready[i] = r_entries[i].valid &&
                         (r_entries[i].rs1_tag == {ROB_TAG_LEN{1'b0}}) &&
                         (r_entries[i].rs2_tag == {ROB_TAG_LEN{1'b0}});
            w_ages[i]  = r_entries[i].age;
        end
    end

    rs_oldest_select #(.N(RS_SIZE), .AGE_W(AGE_W)) u_select (
        .i_ready (w_ready),
        .i_age   (w_ages),
        .o_grant (w_grant),
        .o_idx   (w_sel_idx),
        .o_valid (w_sel_valid)
    );

    // Lowest free slot and free-entry count, both from registered valid bits only.
    always_comb begin
        w_free_idx = '0;
        w_free_cnt = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_entries[i].valid) begin
                w_free_idx = IDX_W'(i);
                w_free_cnt = w_free_cnt + CNT_W'(1);
            end else begin
                w_free_idx = w_free_idx;
            end
        end
    end

    assign w_full       = (w_free_cnt == '0);
    assign w_alloc_fire = alloc_en && !w_full;
    assign w_issue_fire = w_sel_valid && fu_ready;
    assign w_rs1_byp    = tag_hit(cdb_valid, cdb_tag, rs1_rob_tag);
    assign w_rs2_byp    = tag_hit(cdb_valid, cdb_tag, rs2_rob_tag);

    // Incoming packet with any same-cycle CDB result folded in.
    always_comb begin
        w_alloc_pkt = id_packet_in;
        if (w_rs1_byp) begin
            w_alloc_pkt.rs1_value = cdb_value;
        end else begin
            w_alloc_pkt.rs1_value = id_packet_in.rs1_value;
        end
        if (w_rs2_byp) begin
            w_alloc_pkt.rs2_value = cdb_value;
        end else begin
            w_alloc_pkt.rs2_value = id_packet_in.rs2_value;
        end
    end

    // Entry storage: squash beats wakeup/alloc; issued slot frees, alloc fills a free slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                r_entries[i] <= '0;
            end
            r_age_cnt <= '0;
        end else if (squash) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                r_entries[i].valid <= 1'b0;
            end
            r_age_cnt <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_entries[i].valid && tag_hit(cdb_valid, cdb_tag, r_entries[i].rs1_tag)) begin
                    r_entries[i].packet.rs1_value <= cdb_value;
                    r_entries[i].rs1_tag          <= '0;
                end
                if (r_entries[i].valid && tag_hit(cdb_valid, cdb_tag, r_entries[i].rs2_tag)) begin
                    r_entries[i].packet.rs2_value <= cdb_value;
                    r_entries[i].rs2_tag          <= '0;
                end
            end
            if (w_issue_fire) begin
                r_entries[w_sel_idx].valid <= 1'b0;
            end
            if (w_alloc_fire) begin
                r_entries[w_free_idx].valid    <= 1'b1;
                r_entries[w_free_idx].packet   <= w_alloc_pkt;
                r_entries[w_free_idx].rs1_tag  <= w_rs1_byp ? {ROB_TAG_LEN{1'b0}} : rs1_rob_tag;
                r_entries[w_free_idx].rs2_tag  <= w_rs2_byp ? {ROB_TAG_LEN{1'b0}} : rs2_rob_tag;
                r_entries[w_free_idx].dest_tag <= dest_rob_tag;
                r_entries[w_free_idx].age      <= r_age_cnt;
                r_age_cnt                      <= r_age_cnt + AGE_W'(1);
            end
        end
    end

    assign issue_valid   = w_sel_valid;
    assign issue_packet  = w_sel_valid ? r_entries[w_sel_idx].packet   : '0;
    assign issue_rob_tag = w_sel_valid ? r_entries[w_sel_idx].dest_tag : '0;
    assign full          = w_full;
    assign free_count    = w_free_cnt;

endmodule

// File: tb/tb_rs_alu.sv
// Directed self-checking bench for rs_alu: reset, bypass, fill/full, age order,
// back-pressure hold and squash, with hand-computed expectations.
module tb_rs_alu;
    import rs_alu_pkg::*;

    logic                   clock;
    logic                   reset;
    logic                   alloc_en;
    id_ex_packet_t          id_packet_in;
    logic [ROB_TAG_LEN-1:0] rs1_rob_tag;
    logic [ROB_TAG_LEN-1:0] rs2_rob_tag;
    logic [ROB_TAG_LEN-1:0] dest_rob_tag;
    logic                   cdb_valid;
    logic [ROB_TAG_LEN-1:0] cdb_tag;
    logic [XLEN-1:0]        cdb_value;
    logic                   squash;
    logic                   fu_ready;
    logic                   issue_valid;
    id_ex_packet_t          issue_packet;
    logic [ROB_TAG_LEN-1:0] issue_rob_tag;
    logic                   full;
    logic [3:0]             free_count;

    int n_pass  = 0;
    int n_total = 0;

    rs_alu dut (
        .clock         (clock),
        .reset         (reset),
        .alloc_en      (alloc_en),
        .id_packet_in  (id_packet_in),
        .rs1_rob_tag   (rs1_rob_tag),
        .rs2_rob_tag   (rs2_rob_tag),
        .dest_rob_tag  (dest_rob_tag),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_value     (cdb_value),
        .squash        (squash),
        .fu_ready      (fu_ready),
        .issue_valid   (issue_valid),
        .issue_packet  (issue_packet),
        .issue_rob_tag (issue_rob_tag),
        .full          (full),
        .free_count    (free_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        alloc_en     = 1'b0;
        rs1_rob_tag  = 5'd0;
        rs2_rob_tag  = 5'd0;
        dest_rob_tag = 5'd0;
        cdb_valid    = 1'b0;
        cdb_tag      = 5'd0;
        cdb_value    = 32'd0;
        squash       = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] t1, input logic [4:0] t2, input logic [4:0] dst,
                         input logic [31:0] v1, input logic [31:0] v2);
        alloc_en               = 1'b1;
        id_packet_in           = '0;
        id_packet_in.pc        = {27'd0, dst};
        id_packet_in.rs1_value = v1;
        id_packet_in.rs2_value = v2;
        id_packet_in.alu_func  = ALU_ADD;
        rs1_rob_tag            = t1;
        rs2_rob_tag            = t2;
        dest_rob_tag           = dst;
    endtask

    initial begin
        reset        = 1'b1;
        fu_ready     = 1'b0;
        id_packet_in = '0;
        idle();
        step();
        step();
        check("rst_issue_valid", 64'(issue_valid), 64'd0);
        check("rst_issue_tag", 64'(issue_rob_tag), 64'd0);
        check("rst_issue_pkt_pc", 64'(issue_packet.pc), 64'd0);
        check("rst_free_count", 64'(free_count), 64'd8);
        check("rst_full", 64'(full), 64'd0);
        reset = 1'b0;

        // Reset mid-operation with three valid entries
        for (int i = 0; i < 3; i++) begin
            alloc(5'd0, 5'd0, 5'(i + 1), 32'd1, 32'd2);
            step();
        end
        idle();
        check("mid_pre_free", 64'(free_count), 64'd5);
        check("mid_pre_issue", 64'(issue_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_async_issue", 64'(issue_valid), 64'd0);
        check("mid_async_free", 64'(free_count), 64'd8);
        step();
        reset = 1'b0;
        step();
        check("mid_post_issue", 64'(issue_valid), 64'd0);
        check("mid_post_free", 64'(free_count), 64'd8);
        check("mid_post_full", 64'(full), 64'd0);

        // Ready-at-alloc issues one cycle later
        alloc(5'd0, 5'd0, 5'd7, 32'd10, 32'd20);
        check("alloc_same_cycle_no_issue", 64'(issue_valid), 64'd0);
        step();
        idle();
        check("add_issue_valid", 64'(issue_valid), 64'd1);
        check("add_issue_tag", 64'(issue_rob_tag), 64'd7);
        check("add_rs1", 64'(issue_packet.rs1_value), 64'd10);
        check("add_rs2", 64'(issue_packet.rs2_value), 64'd20);
        check("add_free", 64'(free_count), 64'd7);
        fu_ready = 1'b1;
        step();
        fu_ready = 1'b0;
        check("add_drained", 64'(issue_valid), 64'd0);
        check("add_free_after", 64'(free_count), 64'd8);

        // Alloc-cycle CDB bypass on rs1
        alloc(5'd5, 5'd0, 5'd9, 32'd0, 32'd3);
        cdb_valid = 1'b1;
        cdb_tag   = 5'd5;
        cdb_value = 32'hDEAD;
        step();
        idle();
        check("byp_issue_valid", 64'(issue_valid), 64'd1);
        check("byp_issue_tag", 64'(issue_rob_tag), 64'd9);
        check("byp_rs1", 64'(issue_packet.rs1_value), 64'hDEAD);
        check("byp_rs2", 64'(issue_packet.rs2_value), 64'd3);
        fu_ready = 1'b1;
        step();
        fu_ready = 1'b0;
        check("byp_free_after", 64'(free_count), 64'd8);

        // Back-pressure: held for four cycles, then issues
        alloc(5'd0, 5'd0, 5'd11, 32'd4, 32'd5);
        step();
        idle();
        for (int c = 0; c < 4; c++) begin
            check("hold_valid", 64'(issue_valid), 64'd1);
            check("hold_tag", 64'(issue_rob_tag), 64'd11);
            check("hold_rs1", 64'(issue_packet.rs1_value), 64'd4);
            check("hold_free", 64'(free_count), 64'd7);
            step();
        end
        fu_ready = 1'b1;
        step();
        check("hold_released", 64'(issue_valid), 64'd0);
        check("hold_free_after", 64'(free_count), 64'd8);

        // Fill all eight entries waiting on tag 3; ninth alloc ignored
        for (int i = 0; i < 8; i++) begin
            alloc(5'd3, 5'd0, 5'(i + 1), 32'd0, 32'(i));
            step();
        end
        check("fill_full", 64'(full), 64'd1);
        check("fill_free", 64'(free_count), 64'd0);
        check("fill_no_issue", 64'(issue_valid), 64'd0);
        alloc(5'd0, 5'd0, 5'd15, 32'd0, 32'd0);
        step();
        idle();
        check("ninth_full", 64'(full), 64'd1);
        check("ninth_no_issue", 64'(issue_valid), 64'd0);
        cdb_valid = 1'b1;
        cdb_tag   = 5'd3;
        cdb_value = 32'h1234;
        step();
        idle();
        check("wake_valid", 64'(issue_valid), 64'd1);
        check("wake_order_1", 64'(issue_rob_tag), 64'd1);
        check("wake_rs1", 64'(issue_packet.rs1_value), 64'h1234);
        for (int k = 2; k <= 8; k++) begin
            step();
            check("wake_order", 64'(issue_rob_tag), 64'(k));
            check("wake_order_rs2", 64'(issue_packet.rs2_value), 64'(k - 1));
        end
        step();
        check("wake_drained", 64'(issue_valid), 64'd0);
        check("wake_free", 64'(free_count), 64'd8);

        // Age beats index: older entry sits in slot 1, newer one reuses slot 0
        fu_ready = 1'b0;
        alloc(5'd0, 5'd0, 5'd20, 32'd0, 32'd0);
        step();
        alloc(5'd6, 5'd0, 5'd21, 32'd0, 32'd0);
        step();
        idle();
        check("age_first", 64'(issue_rob_tag), 64'd20);
        fu_ready = 1'b1;
        step();
        check("age_slot0_freed", 64'(free_count), 64'd7);
        alloc(5'd6, 5'd0, 5'd22, 32'd0, 32'd0);
        step();
        idle();
        check("age_two_waiting", 64'(free_count), 64'd6);
        check("age_none_ready", 64'(issue_valid), 64'd0);
        cdb_valid = 1'b1;
        cdb_tag   = 5'd6;
        cdb_value = 32'h77;
        step();
        idle();
        check("age_older_hi_idx", 64'(issue_rob_tag), 64'd21);
        step();
        check("age_newer_lo_idx", 64'(issue_rob_tag), 64'd22);
        step();
        check("age_drained", 64'(issue_valid), 64'd0);

        // Squash with alloc and CDB hit in the same cycle
        fu_ready = 1'b0;
        alloc(5'd2, 5'd0, 5'd30, 32'd0, 32'd0);
        step();
        idle();
        check("sq_pre_free", 64'(free_count), 64'd7);
        alloc(5'd0, 5'd0, 5'd31, 32'd0, 32'd0);
        cdb_valid = 1'b1;
        cdb_tag   = 5'd2;
        cdb_value = 32'h55;
        squash    = 1'b1;
        step();
        idle();
        check("sq_free", 64'(free_count), 64'd8);
        check("sq_no_issue", 64'(issue_valid), 64'd0);
        check("sq_full", 64'(full), 64'd0);
        fu_ready = 1'b1;
        step();
        check("sq_alloc_dropped", 64'(issue_valid), 64'd0);
        check("sq_free_hold", 64'(free_count), 64'd8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
